// File: rtl/fp32_pkg.sv
// Shared fp32 constants, default adder latency and accumulator FSM states.
package fp32_pkg;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  localparam int unsigned ADD_LAT_DEFAULT = 11;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_REDUCE = 2'd2,
    ST_DONE   = 2'd3
  } accum_state_e;

endpackage

// File: rtl/fp32_accum_if.sv
// Element stream in / vector sum out for the fp32 accumulator.
interface fp32_accum_if;

  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/addfp32.sv
// Pipelined fp32 adder: flush-to-zero, truncating, overflow saturates to inf.
module addfp32
  import fp32_pkg::*;
#(
  parameter int unsigned LAT = ADD_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic        swap, sub, s_big;
  logic        a_zero, b_zero, a_spec, b_spec;
  logic [7:0]  e_big, e_sml, e_dif;
  logic [26:0] m_big, m_sml, m_aln, norm;
  logic [27:0] mag;
  logic [4:0]  lz;
  logic [9:0]  e_res;
  logic [31:0] sum_c;

  logic [31:0] pipe_q [LAT];
  logic [31:0] pipe_d [LAT];

  // Single-cycle add, then a plain delay pipeline to model the core latency.
  always_comb begin
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_spec = (a[30:23] == 8'hFF);
    b_spec = (b[30:23] == 8'hFF);
    swap   = (b[30:0] > a[30:0]);
    s_big  = swap ? b[31] : a[31];
    e_big  = swap ? b[30:23] : a[30:23];
    e_sml  = swap ? a[30:23] : b[30:23];
    m_big  = {1'b1, (swap ? b[22:0] : a[22:0]), 3'b000};
    m_sml  = {1'b1, (swap ? a[22:0] : b[22:0]), 3'b000};
    e_dif  = e_big - e_sml;
    m_aln  = m_sml >> e_dif;
    sub    = a[31] ^ b[31];
    mag    = sub ? ({1'b0, m_big} - {1'b0, m_aln}) : ({1'b0, m_big} + {1'b0, m_aln});

    lz = '0;
    for (int i = 0; i < 27; i++) begin
      if (mag[i]) lz = 5'(26 - i);
    end

    if (mag[27]) begin
      norm  = mag[27:1];
      e_res = {2'b00, e_big} + 10'd1;
    end else begin
      norm  = 27'(mag << lz);
      e_res = {2'b00, e_big} - {5'b00000, lz};
    end

    sum_c = {s_big, e_res[7:0], 23'(norm >> 3)};
    if (mag == '0) begin
      sum_c = FP32_ZERO;
    end else if (e_res[9] || (e_res == 10'd0)) begin
      sum_c = {s_big, 31'd0};
    end else if (e_res >= 10'd255) begin
      sum_c = {s_big, 8'hFF, 23'd0};
    end

    // Operand classes override the datapath result.
    if (a_spec && b_spec) begin
      sum_c = (a == b) ? a : FP32_QNAN;
    end else if (a_spec) begin
      sum_c = a;
    end else if (b_spec) begin
      sum_c = b;
    end else if (a_zero && b_zero) begin
      sum_c = {a[31] & b[31], 31'd0};
    end else if (a_zero) begin
      sum_c = b;
    end else if (b_zero) begin
      sum_c = a;
    end
  end

  always_comb begin
    pipe_d = pipe_q;
    if (en) begin
      pipe_d[0] = sum_c;
      for (int i = 1; i < LAT; i++) pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign y = pipe_q[LAT-1];

endmodule

// File: rtl/fp32_accum.sv
// Streaming fp32 vector sum: interleaved partial sums hide adder latency,
// then a fixed-schedule pairwise reduction folds them into slot 0.
module fp32_accum
  import fp32_pkg::*;
#(
  parameter int unsigned ADD_LAT = ADD_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  fp32_accum_if.slave io
);

  localparam int unsigned PW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam int unsigned NW = $clog2(ADD_LAT + 1);
  localparam int unsigned CW = $clog2(2 * ADD_LAT + 1);

  localparam logic [1:0] S_ACCUM  = ST_ACCUM;
  localparam logic [1:0] S_DRAIN  = ST_DRAIN;
  localparam logic [1:0] S_REDUCE = ST_REDUCE;
  localparam logic [1:0] S_DONE   = ST_DONE;

  logic [1:0]         state_q, state_d;
  logic [PW-1:0]      p_q, p_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NW-1:0]      n_q, n_d;
  logic [31:0]        slot_q [ADD_LAT];
  logic [31:0]        slot_d [ADD_LAT];
  logic [ADD_LAT-1:0] fresh_q, fresh_d;
  logic [ADD_LAT-1:0] dl_vld_q, dl_vld_d;
  logic [PW-1:0]      dl_tag_q [ADD_LAT];
  logic [PW-1:0]      dl_tag_d [ADD_LAT];
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_data_q, out_data_d;

  logic               accept_c, reducing_c, red_issue_c, issue_c, round_end_c, wb_vld_c;
  logic [PW-1:0]      wb_tag_c, idx_a_c, idx_b_c, idx_odd_c, idx_k_c, issue_tag_c;
  logic [NW-1:0]      k_c;
  logic [31:0]        slot_eff_c [ADD_LAT];
  logic [31:0]        acc_b_c, add_a_c, add_b_c, add_y;

  assign accept_c    = io.in_valid && in_ready_q;
  assign reducing_c  = (state_q == S_REDUCE);
  assign k_c         = n_q >> 1;
  assign red_issue_c = reducing_c && (cnt_q < CW'(k_c));
  assign issue_c     = accept_c || red_issue_c;
  assign round_end_c = reducing_c && (cnt_q == (CW'(k_c) + CW'(ADD_LAT - 1)));
  assign wb_vld_c    = dl_vld_q[ADD_LAT-1];
  assign wb_tag_c    = dl_tag_q[ADD_LAT-1];
  assign idx_odd_c   = PW'(n_q - NW'(1));
  assign idx_k_c     = PW'(k_c);
  assign issue_tag_c = reducing_c ? PW'(cnt_q) : p_q;

  // Unused slots read as +0.0.
  always_comb begin
    for (int i = 0; i < ADD_LAT; i++) slot_eff_c[i] = fresh_q[i] ? FP32_ZERO : slot_q[i];
  end

  always_comb begin
    idx_a_c = '0;
    idx_b_c = '0;
    if (red_issue_c) begin
      idx_a_c = PW'({cnt_q, 1'b0});
      idx_b_c = idx_a_c + PW'(1);
    end
  end

  // Accumulate operand; the write-back landing this cycle wins over the stale slot.
  always_comb begin
    if (wb_vld_c && (wb_tag_c == p_q)) begin
      acc_b_c = add_y;
    end else begin
      acc_b_c = slot_eff_c[p_q];
    end
    if (state_q == S_DONE) acc_b_c = FP32_ZERO;
  end

  assign add_a_c = reducing_c ? slot_eff_c[idx_a_c] : io.in_data;
  assign add_b_c = reducing_c ? slot_eff_c[idx_b_c] : acc_b_c;

  addfp32 #(
    .LAT (ADD_LAT)
  ) u_add (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .a   (add_a_c),
    .b   (add_b_c),
    .y   (add_y)
  );

  always_comb begin
    dl_vld_d    = dl_vld_q;
    dl_tag_d    = dl_tag_q;
    dl_vld_d[0] = issue_c;
    dl_tag_d[0] = issue_tag_c;
    for (int i = 1; i < ADD_LAT; i++) begin
      dl_vld_d[i] = dl_vld_q[i-1];
      dl_tag_d[i] = dl_tag_q[i-1];
    end
  end

  // Slot bank: adder write-back, odd-value carry at round end, re-arm on DONE.
  always_comb begin
    slot_d  = slot_q;
    fresh_d = fresh_q;
    if (wb_vld_c) begin
      slot_d[wb_tag_c]  = add_y;
      fresh_d[wb_tag_c] = 1'b0;
    end
    if (round_end_c && n_q[0]) begin
      slot_d[idx_k_c]  = slot_eff_c[idx_odd_c];
      fresh_d[idx_k_c] = 1'b0;
    end
    if (state_q == S_DONE) fresh_d = '1;
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    case (state_q)
      S_ACCUM, S_DONE: begin
        if (state_q == S_DONE) state_d = S_ACCUM;
        if (accept_c) begin
          p_d = (p_q == PW'(ADD_LAT - 1)) ? '0 : p_q + PW'(1);
          if (io.in_last) begin
            p_d     = '0;
            cnt_d   = '0;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(ADD_LAT - 1)) begin
          cnt_d   = '0;
          n_d     = NW'(ADD_LAT);
          state_d = (ADD_LAT == 1) ? S_DONE : S_REDUCE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_REDUCE: begin
        if (round_end_c) begin
          cnt_d = '0;
          n_d   = k_c + NW'(n_q[0]);
          if ((k_c + NW'(n_q[0])) == NW'(1)) state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_ACCUM;
    endcase
  end

  always_comb begin
    in_ready_d  = (state_d == S_ACCUM) || (state_d == S_DONE);
    out_valid_d = (state_d == S_DONE);
    out_data_d  = out_data_q;
    if (state_d == S_DONE) out_data_d = fresh_d[0] ? FP32_ZERO : slot_d[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_ACCUM;
      p_q         <= '0;
      cnt_q       <= '0;
      n_q         <= NW'(ADD_LAT);
      fresh_q     <= '1;
      dl_vld_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= FP32_ZERO;
      for (int i = 0; i < ADD_LAT; i++) begin
        slot_q[i]   <= '0;
        dl_tag_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      fresh_q     <= fresh_d;
      dl_vld_q    <= dl_vld_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      slot_q      <= slot_d;
      dl_tag_q    <= dl_tag_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;

endmodule
